instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 115 +++++++++++
 tb/tb_instr_encoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns mnemonic/field commands into 32-bit words
// and buffers them in a DEPTH-entry FIFO with a ready/valid handshake on each side.
module instr_encoder #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [4:0]    cmd_mnem,
    input  logic [4:0]    cmd_rs,
    input  logic [4:0]    cmd_rt,
    input  logic [4:0]    cmd_rd,
    input  logic [4:0]    cmd_shamt,
    input  logic [15:0]   cmd_imm,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [31:0]   instr_word,
    output logic          err,
    output logic [7:0]    err_cnt,
    output logic [AW:0]   level
);

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        legal;
    logic        cmd_hs;
    logic        push;
    logic        pop;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic        rtype;
    logic        imm_shift;
    logic [31:0] enc_word;

    always_comb begin
        op        = 6'h00;
        funct     = 6'h00;
        rtype     = 1'b1;
        imm_shift = 1'b0;
        case (cmd_mnem)
            5'd0:  funct = 6'h20;
            5'd1:  funct = 6'h21;
            5'd2:  funct = 6'h22;
            5'd3:  funct = 6'h23;
            5'd4:  funct = 6'h24;
            5'd5:  funct = 6'h25;
            5'd6:  funct = 6'h26;
            5'd7:  funct = 6'h27;
            5'd8:  funct = 6'h2a;
            5'd9:  begin funct = 6'h00; imm_shift = 1'b1; end
            5'd10: begin funct = 6'h02; imm_shift = 1'b1; end
            5'd11: begin funct = 6'h03; imm_shift = 1'b1; end
            5'd12: funct = 6'h04;
            5'd13: funct = 6'h06;
            5'd14: funct = 6'h07;
            5'd15: begin rtype = 1'b0; op = 6'h08; end
            5'd16: begin rtype = 1'b0; op = 6'h09; end
            5'd17: begin rtype = 1'b0; op = 6'h0c; end
            5'd18: begin rtype = 1'b0; op = 6'h0d; end
            5'd19: begin rtype = 1'b0; op = 6'h0e; end
            5'd20: begin rtype = 1'b0; op = 6'h04; end
            5'd21: begin rtype = 1'b0; op = 6'h05; end
            5'd22: begin rtype = 1'b0; op = 6'h23; end
            5'd23: begin rtype = 1'b0; op = 6'h2b; end
            default: ;
        endcase
        // shamt-style shifts carry no rs; every other R-type carries no shamt
        if (rtype)
            enc_word = {6'h00, (imm_shift ? 5'd0 : cmd_rs), cmd_rt, cmd_rd,
                        (imm_shift ? cmd_shamt : 5'd0), funct};
        else
            enc_word = {op, cmd_rs, cmd_rt, cmd_imm};
    end

    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty       = (wr_ptr == rd_ptr);
    assign cmd_ready   = !full;
    assign instr_valid = !empty;
    assign legal       = (cmd_mnem < 5'd24);
    assign cmd_hs      = cmd_valid && cmd_ready;
    assign push        = cmd_hs && legal;
    assign pop         = instr_valid && instr_ready;
    assign level       = wr_ptr - rd_ptr;
    // head is gated so a stale storage entry never shows while empty
    assign instr_word  = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= enc_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            err <= cmd_hs && !legal;
            if (cmd_hs && !legal && (err_cnt != 8'hff))
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: scoreboard of expected words fed at
// command handshakes and checked when words leave the FIFO.
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_mnem;
    logic [4:0]  cmd_rs;
    logic [4:0]  cmd_rt;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_shamt;
    logic [15:0] cmd_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic        err;
    logic [7:0]  err_cnt;
    logic [AW:0] level;

    int passed = 0;
    int total  = 0;
    logic [31:0] q[$];

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mnem(cmd_mnem), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
        .cmd_rd(cmd_rd), .cmd_shamt(cmd_shamt), .cmd_imm(cmd_imm),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_word(instr_word), .err(err), .err_cnt(err_cnt), .level(level)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [4:0] m, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [15:0] imm);
        logic [5:0] code;
        code = 6'h00;
        case (m)
            5'd0:  code = 6'h20;  5'd1:  code = 6'h21;  5'd2:  code = 6'h22;
            5'd3:  code = 6'h23;  5'd4:  code = 6'h24;  5'd5:  code = 6'h25;
            5'd6:  code = 6'h26;  5'd7:  code = 6'h27;  5'd8:  code = 6'h2a;
            5'd9:  code = 6'h00;  5'd10: code = 6'h02;  5'd11: code = 6'h03;
            5'd12: code = 6'h04;  5'd13: code = 6'h06;  5'd14: code = 6'h07;
            5'd15: code = 6'h08;  5'd16: code = 6'h09;  5'd17: code = 6'h0c;
            5'd18: code = 6'h0d;  5'd19: code = 6'h0e;  5'd20: code = 6'h04;
            5'd21: code = 6'h05;  5'd22: code = 6'h23;  5'd23: code = 6'h2b;
            default: ;
        endcase
        if (m >= 5'd15)
            return {code, rs, rt, imm};
        else if (m >= 5'd9 && m <= 5'd11)
            return {6'h00, 5'd0, rt, rd, sh, code};
        else
            return {6'h00, rs, rt, rd, 5'd0, code};
    endfunction

    task automatic randomize_cmd(input logic [4:0] m);
        cmd_mnem  = m;
        cmd_rs    = 5'($urandom_range(31));
        cmd_rt    = 5'($urandom_range(31));
        cmd_rd    = 5'($urandom_range(31));
        cmd_shamt = 5'($urandom_range(31));
        cmd_imm   = 16'($urandom_range(65535));
    endtask

    // One clock: record push/pop at the coming edge, end on the next negedge.
    task automatic step(output bit hs, output bit popped,
                        output logic [31:0] got, output logic [31:0] exp);
        #1;
        hs     = cmd_valid && cmd_ready;
        popped = instr_valid && instr_ready;
        got    = instr_word;
        exp    = 32'hxxxxxxxx;
        if (popped && q.size() > 0) exp = q.pop_front();
        if (hs && cmd_mnem < 5'd24)
            q.push_back(model(cmd_mnem, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b0; instr_ready = 1'b0;
        randomize_cmd(5'd0);
        repeat (2) @(negedge clk);
        total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", instr_valid); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", cmd_ready); else passed++;
        total++; if (instr_word !== 32'h0) $display("FAIL reset_word got=%h exp=0", instr_word); else passed++;
        total++; if (level !== '0) $display("FAIL reset_level got=%0d exp=0", level); else passed++;
        total++; if (err !== 1'b0 || err_cnt !== 8'd0)
            $display("FAIL reset_err got=%b/%0d exp=0/0", err, err_cnt); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_encode;
        bit hs, popped;
        logic [31:0] got, exp;
        for (int m = 0; m < 24; m++) begin
            randomize_cmd(5'(m));
            cmd_valid = 1'b1; instr_ready = 1'b0;
            step(hs, popped, got, exp);
            cmd_valid = 1'b0;
            total++; if (instr_valid !== 1'b1 || level !== 3'd1)
                $display("FAIL enc_latency m=%0d valid=%b level=%0d exp=1/1", m, instr_valid, level); else passed++;
            instr_ready = 1'b1;
            step(hs, popped, got, exp);
            instr_ready = 1'b0;
            total++; if (!popped || got !== exp)
                $display("FAIL enc_word m=%0d got=%h exp=%h", m, got, exp); else passed++;
        end
    endtask

    task automatic test_vectors;
        bit hs, popped;
        logic [31:0] got, exp;
        logic [4:0]  vm  [5] = '{5'd0, 5'd9, 5'd22, 5'd20, 5'd23};
        logic [4:0]  vrs [5] = '{5'd1, 5'd5, 5'd29, 5'd1, 5'd4};
        logic [4:0]  vrt [5] = '{5'd2, 5'd2, 5'd8, 5'd0, 5'd5};
        logic [4:0]  vrd [5] = '{5'd3, 5'd4, 5'd31, 5'd31, 5'd31};
        logic [4:0]  vsh [5] = '{5'd7, 5'd3, 5'd31, 5'd31, 5'd31};
        logic [15:0] vim [5] = '{16'hFFFF, 16'hFFFF, 16'h0010, 16'hFFFF, 16'h0004};
        logic [31:0] vex [5] = '{32'h00221820, 32'h000220C0, 32'h8FA80010, 32'h1020FFFF, 32'hAC850004};
        for (int i = 0; i < 5; i++) begin
            cmd_mnem = vm[i]; cmd_rs = vrs[i]; cmd_rt = vrt[i]; cmd_rd = vrd[i];
            cmd_shamt = vsh[i]; cmd_imm = vim[i];
            cmd_valid = 1'b1;
            step(hs, popped, got, exp);
            cmd_valid = 1'b0;
            total++; if (instr_word !== vex[i])
                $display("FAIL vector_%0d got=%h exp=%h", i, instr_word, vex[i]); else passed++;
            instr_ready = 1'b1;
            step(hs, popped, got, exp);
            instr_ready = 1'b0;
        end
    endtask

    task automatic test_full;
        bit hs, popped;
        logic [31:0] got, exp;
        int accepts = 0, pops = 0;
        instr_ready = 1'b0;
        randomize_cmd(5'($urandom_range(23)));
        cmd_valid = 1'b1;
        for (int i = 0; i < 20 && accepts < DEPTH; i++) begin
            step(hs, popped, got, exp);
            if (hs) begin
                accepts++;
                randomize_cmd(5'($urandom_range(23)));
            end
        end
        total++; if (cmd_ready !== 1'b0 || level !== 3'(DEPTH))
            $display("FAIL full_state ready=%b level=%0d exp=0/%0d", cmd_ready, level, DEPTH); else passed++;
        repeat (2) step(hs, popped, got, exp);
        total++; if (hs || level !== 3'(DEPTH))
            $display("FAIL full_hold hs=%b level=%0d exp=0/%0d", hs, level, DEPTH); else passed++;
        instr_ready = 1'b1;
        #1;
        total++; if (cmd_ready !== 1'b0)
            $display("FAIL full_ready_with_pop got=%b exp=0", cmd_ready); else passed++;
        for (int i = 0; i < 30 && (pops < DEPTH + 1); i++) begin
            step(hs, popped, got, exp);
            if (hs) cmd_valid = 1'b0;
            if (popped) begin
                pops++;
                total++; if (got !== exp)
                    $display("FAIL drain_order n=%0d got=%h exp=%h", pops, got, exp); else passed++;
            end
        end
        instr_ready = 1'b0;
        cmd_valid   = 1'b0;
        total++; if (pops != DEPTH + 1 || instr_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL drain_end pops=%0d valid=%b ready=%b exp=%0d/0/1",
                     pops, instr_valid, cmd_ready, DEPTH + 1); else passed++;
    endtask

    task automatic test_illegal;
        bit hs, popped;
        logic [31:0] got, exp;
        randomize_cmd(5'd25);
        cmd_valid = 1'b1;
        step(hs, popped, got, exp);
        cmd_valid = 1'b0;
        total++; if (err !== 1'b1 || err_cnt !== 8'd1 || level !== '0)
            $display("FAIL illegal_first err=%b cnt=%0d level=%0d exp=1/1/0", err, err_cnt, level); else passed++;
        step(hs, popped, got, exp);
        total++; if (err !== 1'b0)
            $display("FAIL illegal_pulse err=%b exp=0", err); else passed++;
        cmd_valid = 1'b1;
        for (int i = 2; i <= 300; i++) begin
            randomize_cmd(5'($urandom_range(31, 24)));
            step(hs, popped, got, exp);
            if (i == 254) begin
                total++; if (err_cnt !== 8'd254)
                    $display("FAIL illegal_cnt254 got=%0d exp=254", err_cnt); else passed++;
            end
        end
        cmd_valid = 1'b0;
        step(hs, popped, got, exp);
        total++; if (err_cnt !== 8'd255 || instr_valid !== 1'b0 || q.size() != 0)
            $display("FAIL illegal_sat cnt=%0d valid=%b exp=255/0", err_cnt, instr_valid); else passed++;
    endtask

    task automatic test_back_to_back;
        bit hs, popped;
        logic [31:0] got, exp;
        instr_ready = 1'b0;
        cmd_valid   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            randomize_cmd(5'($urandom_range(23)));
            step(hs, popped, got, exp);
        end
        total++; if (level !== 3'd2)
            $display("FAIL b2b_fill level=%0d exp=2", level); else passed++;
        instr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            randomize_cmd(5'($urandom_range(23)));
            step(hs, popped, got, exp);
            total++; if (!popped || !hs || got !== exp || level !== 3'd2)
                $display("FAIL b2b_cycle%0d got=%h exp=%h level=%0d exp_level=2", i, got, exp, level); else passed++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (instr_valid !== 1'b0 || level !== '0 || cmd_ready !== 1'b1)
            $display("FAIL midreset valid=%b level=%0d ready=%b exp=0/0/1", instr_valid, level, cmd_ready); else passed++;
        q.delete();
        cmd_valid = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        randomize_cmd(5'd0);
        cmd_valid = 1'b1;
        step(hs, popped, got, exp);
        cmd_valid = 1'b0;
        total++; if (!hs || level !== 3'd1 || instr_valid !== 1'b1)
            $display("FAIL post_reset_accept hs=%b level=%0d exp=1/1", hs, level); else passed++;
        instr_ready = 1'b1;
        step(hs, popped, got, exp);
        instr_ready = 1'b0;
        total++; if (!popped || got !== exp)
            $display("FAIL post_reset_word got=%h exp=%h", got, exp); else passed++;
    endtask

    initial begin
        test_reset();
        test_encode();
        test_vectors();
        test_full();
        test_illegal();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
